// File: rtl/dircc_rts_arbiter_pkg.sv
// Shared types for the DiRCC ready-to-send arbiter: FSM states and pin index limits.
package dircc_types_pkg;

    localparam int DIRCC_MAX_OUTPUT_PINS = 32;

    typedef logic [$clog2(DIRCC_MAX_OUTPUT_PINS)-1:0] dircc_pin_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SELECT = 2'd1,
        ARB_OFFER  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dircc_rts_arbiter_if.sv
// Snapshot-in / pin-offer-out bundle between device-state read port, arbiter and send stage.
interface dircc_rts_arbiter_if #(
    parameter int NUM_PINS = 4,
    parameter int COUNT_W  = 16
);
    localparam int PIN_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;

    logic                state_valid;
    logic                state_ready;
    logic [NUM_PINS-1:0] rts_vec;
    logic [COUNT_W-1:0]  count;
    logic [COUNT_W-1:0]  max_time;
    logic                send_valid;
    logic [PIN_W-1:0]    send_pin;
    logic                send_ready;
    logic [NUM_PINS-1:0] rts_clear;
    logic                done;

    modport master (
        output state_valid, rts_vec, count, max_time, send_ready,
        input  state_ready, send_valid, send_pin, rts_clear, done
    );

    modport slave (
        input  state_valid, rts_vec, count, max_time, send_ready,
        output state_ready, send_valid, send_pin, rts_clear, done
    );

endinterface

// File: rtl/dircc_rts_arbiter_pick.sv
// Combinational pick of the first set mask bit at or after i_ptr, wrapping at NUM_PINS.
module dircc_rts_pick
    import dircc_types_pkg::*;
#(
    parameter int NUM_PINS = 4,
    parameter int PIN_W    = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
    input  logic [NUM_PINS-1:0] i_mask,
    input  logic [PIN_W-1:0]    i_ptr,
    output logic [PIN_W-1:0]    o_idx,
    output logic                o_found
);

    function automatic logic [PIN_W-1:0] wrap_add(input logic [PIN_W-1:0] a,
                                                  input logic [PIN_W-1:0] b);
        logic [PIN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (PIN_W+1)'(NUM_PINS)) begin
            s = s - (PIN_W+1)'(NUM_PINS);
        end
        return s[PIN_W-1:0];
    endfunction

    // Rotate the mask so the pointer position lands at bit 0.
    logic [NUM_PINS-1:0] w_rot;
    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_rot
        assign w_rot[gi] = i_mask[wrap_add(i_ptr, PIN_W'(gi))];
    end

    logic [PIN_W-1:0] w_off;
    logic             w_found;

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int k = NUM_PINS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = PIN_W'(k);
                w_found = 1'b1;
            end
        end
    end

    assign o_idx   = wrap_add(i_ptr, w_off);
    assign o_found = w_found;

endmodule

// File: rtl/dircc_rts_arbiter.sv
// Ready-to-send handler: offers each pending output pin of a gated snapshot to the send stage.
// Macro DIRCC_RTS_ROUND_ROBIN_EN selects round-robin picking; undefined gives fixed priority.
module dircc_rts_arbiter
    import dircc_types_pkg::*;
#(
    parameter int NUM_PINS = 4,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    dircc_rts_arbiter_if.slave bus
);

    localparam int PIN_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;

    arb_state_e          r_state,     w_state_next;
    logic [NUM_PINS-1:0] r_pending,   w_pending_next;
    logic [PIN_W-1:0]    r_send_pin,  w_send_pin_next;
    logic [NUM_PINS-1:0] r_rts_clear, w_rts_clear_next;
    logic                r_done,      w_done_next;

    logic [COUNT_W-1:0]  w_count;
    logic [COUNT_W-1:0]  w_max_time;
    logic                w_going;
    logic [NUM_PINS-1:0] w_sel_bit;
    logic [PIN_W-1:0]    w_ptr;
    logic [PIN_W-1:0]    w_pick_idx;
    logic                w_pick_found;

    assign w_count    = bus.count;
    assign w_max_time = bus.max_time;
    assign w_going    = (w_count < w_max_time);
    assign w_sel_bit  = NUM_PINS'(1) << r_send_pin;

`ifdef DIRCC_RTS_ROUND_ROBIN_EN
    logic [PIN_W-1:0] r_ptr, w_ptr_next;
    logic [PIN_W-1:0] w_pin_inc;

    assign w_ptr     = r_ptr;
    assign w_pin_inc = (r_send_pin == PIN_W'(NUM_PINS - 1)) ? '0 : r_send_pin + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    assign w_ptr = '0;
`endif

    dircc_rts_pick #(
        .NUM_PINS (NUM_PINS),
        .PIN_W    (PIN_W)
    ) u_pick (
        .i_mask  (r_pending),
        .i_ptr   (w_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_pending   <= '0;
            r_send_pin  <= '0;
            r_rts_clear <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_send_pin  <= w_send_pin_next;
            r_rts_clear <= w_rts_clear_next;
            r_done      <= w_done_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pending_next   = r_pending;
        w_send_pin_next  = r_send_pin;
        w_rts_clear_next = '0;
        w_done_next      = 1'b0;
`ifdef DIRCC_RTS_ROUND_ROBIN_EN
        w_ptr_next       = r_ptr;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (bus.state_valid) begin
                    w_pending_next = w_going ? bus.rts_vec : '0;
                    if (w_pending_next == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = ARB_SELECT;
                    end
                end
            end
            ARB_SELECT: begin
                // Pending is never empty here; the fallback just keeps the FSM safe.
                if (w_pick_found) begin
                    w_send_pin_next = w_pick_idx;
                    w_state_next    = ARB_OFFER;
                end else begin
                    w_done_next  = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_OFFER: begin
                if (bus.send_ready) begin
                    w_pending_next   = r_pending & ~w_sel_bit;
                    w_rts_clear_next = w_sel_bit;
`ifdef DIRCC_RTS_ROUND_ROBIN_EN
                    w_ptr_next       = w_pin_inc;
`endif
                    if (w_pending_next == '0) begin
                        w_done_next  = 1'b1;
                        w_state_next = ARB_IDLE;
                    end else begin
                        w_state_next = ARB_SELECT;
                    end
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign bus.state_ready = (r_state == ARB_IDLE);
    assign bus.send_valid  = (r_state == ARB_OFFER);
    assign bus.send_pin    = r_send_pin;
    assign bus.rts_clear   = r_rts_clear;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_dircc_rts_arbiter.sv
// Directed bench for dircc_rts_arbiter: snapshot table plus backpressure and reset sequences.
module tb_dircc_rts_arbiter;

    localparam int NUM_PINS = 4;
    localparam int COUNT_W  = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    dircc_rts_arbiter_if #(.NUM_PINS(NUM_PINS), .COUNT_W(COUNT_W)) bus ();

    dircc_rts_arbiter #(.NUM_PINS(NUM_PINS), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       rts;
        logic [15:0]      cnt;
        logic [15:0]      mx;
        int               n;
        logic [3:0][1:0]  pins;
    } snap_t;

    snap_t snaps [9];

    function automatic snap_t mk(input logic [3:0] rts, input logic [15:0] cnt,
                                 input logic [15:0] mx, input int n,
                                 input logic [1:0] p0, input logic [1:0] p1,
                                 input logic [1:0] p2, input logic [1:0] p3);
        snap_t s;
        s.rts = rts; s.cnt = cnt; s.mx = mx; s.n = n;
        s.pins[0] = p0; s.pins[1] = p1; s.pins[2] = p2; s.pins[3] = p3;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_snap(input int idx, input snap_t v);
        logic [3:0] onehot;
        bus.state_valid = 1'b1;
        bus.rts_vec     = v.rts;
        bus.count       = v.cnt;
        bus.max_time    = v.mx;
        check("state_ready_before", {31'd0, bus.state_ready}, 32'd1);
        tick();
        bus.state_valid = 1'b0;
        if (v.n == 0) begin
            check("empty_done", {31'd0, bus.done}, 32'd1);
            check("empty_send_valid", {31'd0, bus.send_valid}, 32'd0);
            check("empty_state_ready", {31'd0, bus.state_ready}, 32'd1);
            tick();
            check("empty_done_off", {31'd0, bus.done}, 32'd0);
            check("empty_send_valid2", {31'd0, bus.send_valid}, 32'd0);
        end else begin
            check("select_done", {31'd0, bus.done}, 32'd0);
            check("select_send_valid", {31'd0, bus.send_valid}, 32'd0);
            for (int k = 0; k < v.n; k++) begin
                tick();
                check("offer_valid", {31'd0, bus.send_valid}, 32'd1);
                check("offer_pin", {30'd0, bus.send_pin}, {30'd0, v.pins[k]});
                onehot = 4'b0001 << v.pins[k];
                tick();
                check("rts_clear", {28'd0, bus.rts_clear}, {28'd0, onehot});
                check("done", {31'd0, bus.done}, (k == v.n - 1) ? 32'd1 : 32'd0);
                check("valid_after_accept", {31'd0, bus.send_valid}, 32'd0);
            end
        end
        $display("snapshot %0d rts=%b count=%0d max=%0d offers=%0d errors=%0d",
                 idx, v.rts, v.cnt, v.mx, v.n, errors);
    endtask

    initial begin
        snaps[0] = mk(4'b1010, 16'd10,    16'd10,  0, 2'd0, 2'd0, 2'd0, 2'd0);
        snaps[1] = mk(4'b1011, 16'd0,     16'd5,   3, 2'd0, 2'd1, 2'd3, 2'd0);
        snaps[2] = mk(4'b0011, 16'd0,     16'd5,   2, 2'd0, 2'd1, 2'd0, 2'd0);
`ifdef DIRCC_RTS_ROUND_ROBIN_EN
        snaps[3] = mk(4'b1001, 16'd3,     16'd100, 2, 2'd3, 2'd0, 2'd0, 2'd0);
`else
        snaps[3] = mk(4'b1001, 16'd3,     16'd100, 2, 2'd0, 2'd3, 2'd0, 2'd0);
`endif
        snaps[4] = mk(4'b0100, 16'd0,     16'd5,   1, 2'd2, 2'd0, 2'd0, 2'd0);
        snaps[5] = mk(4'b1111, 16'hFFFF,  16'd0,   0, 2'd0, 2'd0, 2'd0, 2'd0);
        snaps[6] = mk(4'b0110, 16'd4,     16'd5,   2, 2'd1, 2'd2, 2'd0, 2'd0);
        snaps[7] = mk(4'b1000, 16'd9,     16'd10,  1, 2'd3, 2'd0, 2'd0, 2'd0);
        snaps[8] = mk(4'b1001, 16'd1,     16'd2,   2, 2'd0, 2'd3, 2'd0, 2'd0);

        bus.state_valid = 1'b0;
        bus.rts_vec     = '0;
        bus.count       = '0;
        bus.max_time    = '0;
        bus.send_ready  = 1'b1;

        tick();
        tick();
        reset = 1'b0;
        check("rst_state_ready", {31'd0, bus.state_ready}, 32'd1);
        check("rst_send_valid", {31'd0, bus.send_valid}, 32'd0);
        check("rst_send_pin", {30'd0, bus.send_pin}, 32'd0);
        check("rst_rts_clear", {28'd0, bus.rts_clear}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_snap(i, snaps[i]);
        end

        // Backpressure: offer held, snapshot input ignored while busy.
        bus.send_ready  = 1'b0;
        bus.state_valid = 1'b1;
        bus.rts_vec     = 4'b0110;
        bus.count       = 16'd0;
        bus.max_time    = 16'd5;
        tick();
        bus.state_valid = 1'b0;
        tick();
        check("bp_valid", {31'd0, bus.send_valid}, 32'd1);
        check("bp_pin", {30'd0, bus.send_pin}, 32'd1);
        bus.state_valid = 1'b1;
        bus.rts_vec     = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", {31'd0, bus.send_valid}, 32'd1);
            check("bp_hold_pin", {30'd0, bus.send_pin}, 32'd1);
            check("bp_hold_clear", {28'd0, bus.rts_clear}, 32'd0);
            check("bp_hold_done", {31'd0, bus.done}, 32'd0);
            check("bp_hold_ready", {31'd0, bus.state_ready}, 32'd0);
        end
        bus.state_valid = 1'b0;
        bus.send_ready  = 1'b1;
        tick();
        check("bp_clear1", {28'd0, bus.rts_clear}, 32'h2);
        check("bp_done1", {31'd0, bus.done}, 32'd0);
        tick();
        check("bp_valid2", {31'd0, bus.send_valid}, 32'd1);
        check("bp_pin2", {30'd0, bus.send_pin}, 32'd2);
        tick();
        check("bp_clear2", {28'd0, bus.rts_clear}, 32'h4);
        check("bp_done2", {31'd0, bus.done}, 32'd1);
        $display("backpressure sequence errors=%0d", errors);

        // Reset while an offer is outstanding.
        bus.send_ready  = 1'b0;
        bus.state_valid = 1'b1;
        bus.rts_vec     = 4'b0001;
        tick();
        bus.state_valid = 1'b0;
        tick();
        check("mr_valid", {31'd0, bus.send_valid}, 32'd1);
        check("mr_pin", {30'd0, bus.send_pin}, 32'd0);
        reset          = 1'b1;
        bus.send_ready = 1'b1;
        tick();
        check("mr_send_valid", {31'd0, bus.send_valid}, 32'd0);
        check("mr_rts_clear", {28'd0, bus.rts_clear}, 32'd0);
        check("mr_done", {31'd0, bus.done}, 32'd0);
        check("mr_send_pin", {30'd0, bus.send_pin}, 32'd0);
        check("mr_state_ready", {31'd0, bus.state_ready}, 32'd1);
        reset = 1'b0;
        $display("reset mid-offer sequence errors=%0d", errors);
        run_snap(9, mk(4'b1001, 16'd0, 16'd5, 2, 2'd0, 2'd3, 2'd0, 2'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_rts_arbiter.md
# dircc_rts_arbiter

Parametrised ready-to-send handler for DiRCC processing devices. Takes a device-state snapshot (per-output-pin RTS bits plus progress counter), gates it with the stillGoing condition (count < max_time), and offers each pending output pin, one at a time, to the send stage over a valid/ready handshake. It emits a one-hot clear for each accepted pin so the state write-back path can drop that RTS bit. It sits between the device-state read port and the message send stage, replacing the single-pin, single-cycle RTS flag.

## Interface
- NUM_PINS, 4, number of output pins (1..32)
- COUNT_W, 16, width of count and max_time
- PIN_W, max(1,$clog2(NUM_PINS)), pin index width (derived, not overridden)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- state_valid  in  1  snapshot presented
- state_ready  out  1  handler accepts snapshot (IDLE only)
- rts_vec  in  NUM_PINS  per-pin RTS bits from user state
- count  in  COUNT_W  device progress counter
- max_time  in  COUNT_W  instance property limit
- send_valid  out  1  pin offered to send stage
- send_pin  out  PIN_W  offered pin index
- send_ready  in  1  send stage accepts offer
- rts_clear  out  NUM_PINS  one-hot, one-cycle pulse of accepted pin
- done  out  1  one-cycle pulse, snapshot fully handled

## Operation
- States: IDLE, SELECT, OFFER.
- IDLE: state_ready=1. On state_valid: pending <= rts_vec masked by (count < max_time), unsigned compare. If the masked vector is zero: pulse done next cycle, stay IDLE. Else go to SELECT.
- count == max_time means not going: all pins are masked.
- SELECT (1 cycle): the arbiter picks a pin from pending; register it into send_pin; go to OFFER.
- OFFER: send_valid=1; send_pin is held stable until accepted. On send_ready:
  - clear that bit in pending;
  - register a rts_clear one-hot pulse;
  - advance the pointer to (pin+1) mod NUM_PINS;
  - if remaining pending == 0: pulse done and go to IDLE; else go to SELECT.
- state_valid outside IDLE is ignored; upstream must hold it until state_ready.
- send_valid never deasserts without acceptance, except on reset.

## Timing
- Reset values: state IDLE, pending 0, pointer 0, send_valid 0, send_pin 0, rts_clear 0, done 0. state_ready=1 from the first cycle after reset.
- Reset mid-OFFER: send_valid low on the next cycle, no rts_clear, no done, pending discarded.
- Snapshot accept (cycle 0) to send_valid: cycle 2.
- Accept (send_valid & send_ready at cycle n) to rts_clear and done: both at cycle n+1.
- Next offer's send_valid: cycle n+2. Sustained rate is one pin per 2 cycles.
- Empty snapshot: done at cycle 1, state_ready stays 1.
- Pointer wraps from NUM_PINS-1 to 0. The pointer persists across snapshots.

## Configuration
- DIRCC_RTS_ROUND_ROBIN_EN defined: the pick is the first pending pin at or after the pointer, with wrap-around.
- Undefined: fixed priority, lowest pending index wins. The pointer register is not built and the pointer is treated as 0.

## Structure
- In dircc_types_pkg:
  - typedef enum for the arbiter states;
  - constant DIRCC_MAX_OUTPUT_PINS = 32;
  - pin index typedef sized from that constant.
- One sub-module: dircc_rts_pick. Combinational; inputs are the mask and the pointer; outputs are the index and a found flag. Shared by both configuration modes.

## Test plan
- Empty snapshot: NUM_PINS=4, rts_vec=4'b1010, count=10, max_time=10 -> done at cycle 1; send_valid never asserts.
- Single pin: rts_vec=4'b0100, count=0, max_time=5, send_ready=1 -> send_valid at cycle 2 with send_pin=2; rts_clear=4'b0100 and done at cycle 3.
- Round robin (macro defined): pointer=0, rts_vec=4'b1011, send_ready=1 -> pins offered 0,1,3; three rts_clear pulses; done with the last. Next snapshot rts_vec=4'b0011 -> offer order 0,1.
- Fixed priority (macro undefined): after serving pin 3, next snapshot rts_vec=4'b1001 -> pin 0 first.
- Backpressure: send_ready low for 5 cycles in OFFER -> send_valid and send_pin stable; state_valid ignored; no rts_clear until acceptance.
- Reset mid-OFFER: assert reset while send_valid=1 -> all outputs 0 next cycle; a fresh snapshot is accepted normally and the pointer has restarted at 0.
